tlc_lamp_guard: RTL and testbench
=================================

# tlc_lamp_guard

Downstream stage of the traffic-light controller FSM. It takes the FSM's `highwaySignal`/`farmSignal` colour codes and drives the six physical lamps, one red/yellow/green triple per road. It also checks every cycle for unsafe or illegal signal behaviour. On any violation it latches a fault, holds the FSM in reset and flashes both red lamps until an operator clears the fault.

## Interface
- `BLINK_HALF`, default 50000000: cycles per half-period of the fault flash (ON phase, then OFF phase).
- `MIN_YELLOW`, default 150000000: minimum number of consecutive yellow samples required before a road may go red.
- `Clk` in 1: clock.
- `Rst` in 1: synchronous, active-high reset.
- `highwaySignal` in 2: colour code from the FSM; green=00, yellow=01, red=10, 11 illegal.
- `farmSignal` in 2: same encoding, farm road.
- `FaultClr` in 1: operator clear; acts only in FAULT.
- `hwLamp` out 3: {R,Y,G} lamp drives for the highway, registered.
- `farmLamp` out 3: {R,Y,G} lamp drives for the farm road, registered.
- `fault` out 1: high while in FAULT.
- `faultCode` out 3: code of the latched violation; 0 = none.
- `faultHold` out 1: equals `fault`; ORed externally into the FSM `Rst`.

## Operation
- Two states.
  - NORMAL: checks enabled; lamps decode the sampled colour codes (00→001, 01→010, 10→100).
  - FAULT: checks disabled; colour inputs ignored.
- Registered history per road:
  - `prev` colour, reset to red.
  - 31-bit `ydwell` count. It increments (saturating at 2^31−1) on each sample that is yellow and clears to 0 on any non-yellow sample.
- Violations in NORMAL, evaluated on the current sample against `prev`/`ydwell`:
  - code 1: either input is 11.
  - code 2: both roads non-red in the same sample.
  - code 3: a road goes from green directly to red.
  - code 4: a road goes from red directly to yellow.
  - code 5: a road goes from yellow to red with `ydwell` < MIN_YELLOW.
  - code 6: a road goes from yellow directly to green.
- If several violations occur in one cycle, the lowest code is latched.
- NORMAL → FAULT on any violation:
  - `fault`, `faultHold` and `faultCode` are set.
  - Blink counter is cleared and phase set to ON.
- FAULT behaviour:
  - Both red lamps follow the blink phase; yellow and green lamps are 0.
  - Blink counter counts 0..BLINK_HALF−1; at the terminal count it wraps to 0 and toggles the phase.
- FAULT → NORMAL on `FaultClr`=1:
  - `fault`, `faultHold` and `faultCode` clear to 0.
  - `prev` is loaded with red/red and both `ydwell` clear to 0.
  - Lamps go to solid red/red (100/100).
  - The FSM then restarts from its own reset state.
- `FaultClr` in NORMAL is ignored.
- A `FaultClr` in FAULT wins over any colour input in the same cycle.

## Timing
- Reset values:
  - state NORMAL; `hwLamp`=`farmLamp`=100; `fault`=0; `faultCode`=0; `faultHold`=0.
  - `prev`=red/red; `ydwell`=0; blink counter 0; phase ON.
- `Rst` is honoured in any state, including mid-FAULT; it returns the block to the reset values on the next edge.
- Lamp latency in NORMAL: inputs sampled at edge k appear on the lamps after edge k (1 cycle).
- Fault latency:
  - A violating sample at edge k gives `fault`=1 and red lamps ON after edge k.
  - The offending colour is never driven to the lamps.
- Blink waveform: first ON phase lasts exactly BLINK_HALF cycles, then OFF for BLINK_HALF cycles, repeating. With BLINK_HALF=1 the red lamps toggle every cycle.
- `ydwell` boundary: yellow held for exactly MIN_YELLOW samples, then red, is legal. MIN_YELLOW−1 samples gives code 5.
- Clear timing: `FaultClr` sampled at edge k puts the block in NORMAL with lamps 100/100 after edge k. Checks resume on the sample at edge k+1, against `prev`=red/red.

## Test plan
Benches use BLINK_HALF=4 and MIN_YELLOW=3.

- Legal cycle: red/red ×2 → hw green ×5 → hw yellow ×3 → red/red ×2 → farm green ×5 → farm yellow ×3 → red/red. Lamps track with 1-cycle lag; `fault` stays 0 throughout.
- Short yellow: hw green → yellow ×2 → red. At the red sample, `faultCode`=5 and `fault`=`faultHold`=1. Red lamps then run ON 4 / OFF 4 / ON 4 while the inputs keep changing.
- Conflict plus illegal code in one sample: hw=00, farm=11. `faultCode`=1 (priority rule); the lamps never show green.
- Direct transitions, each from a fresh reset:
  - hw green→red gives code 3.
  - farm red→yellow gives code 4.
  - hw yellow×3→green gives code 6.
- Clear handling:
  - `FaultClr` pulsed in NORMAL: no effect.
  - `FaultClr` in FAULT during the OFF phase: next cycle lamps 100/100 and `faultCode`=0.
  - A following hw yellow sample gives code 4 (history was reloaded to red).
- `Rst` asserted mid-FAULT: after one edge, all outputs return to their reset values.

Source files
------------

// File: rtl/tlc_lamp_guard_if.sv
// tlc_lamp_guard_if: colour inputs, operator clear and lamp/fault outputs of the lamp guard
interface tlc_lamp_guard_if;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic       FaultClr;
  logic [2:0] hwLamp;
  logic [2:0] farmLamp;
  logic       fault;
  logic [2:0] faultCode;
  logic       faultHold;
  modport master (
    output highwaySignal, farmSignal, FaultClr,
    input  hwLamp, farmLamp, fault, faultCode, faultHold
  );
  modport slave (
    input  highwaySignal, farmSignal, FaultClr,
    output hwLamp, farmLamp, fault, faultCode, faultHold
  );
endinterface

// File: rtl/tlc_lamp_guard.sv
// tlc_lamp_guard: drives the six lamps from the FSM colour codes and latches safety faults
module tlc_lamp_guard #(
  parameter int BLINK_HALF = 50000000,
  parameter int MIN_YELLOW = 150000000
) (
  input logic             Clk,
  input logic             Rst,
  tlc_lamp_guard_if.slave bus
);
  localparam int CW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_HALF - 1);
  localparam logic [30:0] YD_MIN = 31'(MIN_YELLOW);
  localparam logic [1:0] GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, ILLEGAL = 2'b11;
  localparam logic [2:0] LAMP_RED = 3'b100;
  typedef enum logic {NORMAL, FAULT} state_t;
  state_t        state_q, state_d;
  logic [1:0]    hw_prev_q, hw_prev_d, fm_prev_q, fm_prev_d;
  logic [30:0]   hw_yd_q, hw_yd_d, fm_yd_q, fm_yd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    hw_lamp_q, hw_lamp_d, fm_lamp_q, fm_lamp_d;
  logic [2:0]    hw_code, fm_code, viol;
  logic [1:0]    hw, fm;
  function automatic logic [2:0] decode(input logic [1:0] c);
    return {c == RED, c == YELLOW, c == GREEN};
  endfunction
  function automatic logic [2:0] road_check(input logic [1:0] c, input logic [1:0] p, input logic [30:0] yd);
    return (p == GREEN  && c == RED)                ? 3'd3 :
           (p == RED    && c == YELLOW)             ? 3'd4 :
           (p == YELLOW && c == RED && yd < YD_MIN) ? 3'd5 :
           (p == YELLOW && c == GREEN)              ? 3'd6 : 3'd0;
  endfunction
  function automatic logic [30:0] dwell(input logic [1:0] c, input logic [30:0] yd);
    return c != YELLOW ? '0 : (&yd ? yd : yd + 31'd1);
  endfunction
  assign hw = bus.highwaySignal;
  assign fm = bus.farmSignal;
  // Violation code of the current sample, lowest code wins when several apply
  always_comb begin
    hw_code = road_check(hw, hw_prev_q, hw_yd_q);
    fm_code = road_check(fm, fm_prev_q, fm_yd_q);
    viol = (hw == ILLEGAL || fm == ILLEGAL) ? 3'd1 :
           (hw != RED && fm != RED)         ? 3'd2 :
           (hw_code == 3'd0)                ? fm_code :
           (fm_code == 3'd0 || hw_code < fm_code) ? hw_code : fm_code;
  end
  // Next state: lamp decode and history in NORMAL, red flash until cleared in FAULT
  always_comb begin
    state_d   = state_q;
    hw_prev_d = hw_prev_q;
    fm_prev_d = fm_prev_q;
    hw_yd_d   = hw_yd_q;
    fm_yd_d   = fm_yd_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    code_d    = code_q;
    hw_lamp_d = hw_lamp_q;
    fm_lamp_d = fm_lamp_q;
    if (state_q == FAULT) begin
      if (bus.FaultClr) begin
        state_d   = NORMAL;
        code_d    = 3'd0;
        hw_prev_d = RED;
        fm_prev_d = RED;
        hw_yd_d   = '0;
        fm_yd_d   = '0;
        hw_lamp_d = LAMP_RED;
        fm_lamp_d = LAMP_RED;
      end else begin
        cnt_d     = cnt_q == BLINK_TC ? '0 : cnt_q + 1'b1;
        phase_d   = cnt_q == BLINK_TC ? ~phase_q : phase_q;
        hw_lamp_d = {phase_d, 2'b00};
        fm_lamp_d = {phase_d, 2'b00};
      end
    end else if (viol != 3'd0) begin
      state_d   = FAULT;
      code_d    = viol;
      cnt_d     = '0;
      phase_d   = 1'b1;
      hw_lamp_d = LAMP_RED;
      fm_lamp_d = LAMP_RED;
    end else begin
      hw_lamp_d = decode(hw);
      fm_lamp_d = decode(fm);
      hw_prev_d = hw;
      fm_prev_d = fm;
      hw_yd_d   = dwell(hw, hw_yd_q);
      fm_yd_d   = dwell(fm, fm_yd_q);
    end
  end
  // State and history registers, reset to solid red on both roads
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= NORMAL;
      hw_prev_q <= RED;
      fm_prev_q <= RED;
      hw_yd_q   <= '0;
      fm_yd_q   <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b1;
      code_q    <= 3'd0;
      hw_lamp_q <= LAMP_RED;
      fm_lamp_q <= LAMP_RED;
    end else begin
      state_q   <= state_d;
      hw_prev_q <= hw_prev_d;
      fm_prev_q <= fm_prev_d;
      hw_yd_q   <= hw_yd_d;
      fm_yd_q   <= fm_yd_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
      hw_lamp_q <= hw_lamp_d;
      fm_lamp_q <= fm_lamp_d;
    end
  end
  assign bus.hwLamp    = hw_lamp_q;
  assign bus.farmLamp  = fm_lamp_q;
  assign bus.fault     = state_q == FAULT;
  assign bus.faultHold = state_q == FAULT;
  assign bus.faultCode = code_q;
endmodule

// File: tb/tb_tlc_lamp_guard.sv
// tb_tlc_lamp_guard: directed and random stimulus checked against a rule-level lamp guard model
module tb_tlc_lamp_guard;
  localparam int BH = 4;
  localparam int MY = 3;
  logic Clk = 1'b0;
  logic Rst;
  int n_vec = 0;
  int n_bad = 0;
  int m_fault, m_code, m_age, m_prev_hw, m_prev_fm, m_yd_hw, m_yd_fm;
  logic [2:0] m_hw_lamp, m_fm_lamp;
  tlc_lamp_guard_if bus();
  tlc_lamp_guard #(.BLINK_HALF(BH), .MIN_YELLOW(MY)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] lamp_of(input int c);
    return c == 0 ? 3'b001 : c == 1 ? 3'b010 : 3'b100;
  endfunction
  function automatic int road_rule(input int cur, input int prev, input int yd);
    if (prev == 0 && cur == 2) return 3;
    if (prev == 2 && cur == 1) return 4;
    if (prev == 1 && cur == 2 && yd < MY) return 5;
    if (prev == 1 && cur == 0) return 6;
    return 0;
  endfunction
  function automatic int violation(input int hw, input int fm);
    int a, b;
    if (hw == 3 || fm == 3) return 1;
    if (hw != 2 && fm != 2) return 2;
    a = road_rule(hw, m_prev_hw, m_yd_hw);
    b = road_rule(fm, m_prev_fm, m_yd_fm);
    if (a == 0) return b;
    if (b == 0) return a;
    return a < b ? a : b;
  endfunction
  task automatic model_step(input int r, input int hw, input int fm, input int clr);
    int v;
    if (r != 0 || (m_fault != 0 && clr != 0)) begin
      m_fault = 0; m_code = 0; m_age = 0;
      m_prev_hw = 2; m_prev_fm = 2; m_yd_hw = 0; m_yd_fm = 0;
      m_hw_lamp = 3'b100; m_fm_lamp = 3'b100;
    end else if (m_fault != 0) begin
      m_age++;
      m_hw_lamp = ((m_age / BH) % 2 == 0) ? 3'b100 : 3'b000;
      m_fm_lamp = m_hw_lamp;
    end else begin
      v = violation(hw, fm);
      if (v != 0) begin
        m_fault = 1; m_code = v; m_age = 0;
        m_hw_lamp = 3'b100; m_fm_lamp = 3'b100;
      end else begin
        m_hw_lamp = lamp_of(hw); m_fm_lamp = lamp_of(fm);
        m_yd_hw = hw == 1 ? m_yd_hw + 1 : 0;
        m_yd_fm = fm == 1 ? m_yd_fm + 1 : 0;
        m_prev_hw = hw; m_prev_fm = fm;
      end
    end
  endtask
  task automatic cyc(input int r, input int hw, input int fm, input int clr, input string tag);
    @(negedge Clk);
    Rst = r[0];
    bus.highwaySignal = 2'(hw);
    bus.farmSignal = 2'(fm);
    bus.FaultClr = clr[0];
    @(posedge Clk);
    model_step(r, hw, fm, clr);
    #1;
    chk({tag, "_lamps"}, {10'd0, bus.hwLamp, bus.farmLamp}, {10'd0, m_hw_lamp, m_fm_lamp});
    chk({tag, "_fault"}, {11'd0, bus.fault, bus.faultCode, bus.faultHold}, {11'd0, m_fault[0], 3'(m_code), m_fault[0]});
  endtask
  task automatic hold(input int hw, input int fm, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, hw, fm, 0, tag);
  endtask
  task automatic reset2();
    cyc(1, 2, 2, 0, "rst");
    cyc(1, 2, 2, 0, "rst");
  endtask
  initial begin
    int hw, fm;
    Rst = 1'b1;
    bus.highwaySignal = 2'b10;
    bus.farmSignal = 2'b10;
    bus.FaultClr = 1'b0;
    reset2();
    chk("reset_out", {5'd0, bus.hwLamp, bus.farmLamp, bus.fault, bus.faultCode, bus.faultHold}, {5'd0, 3'b100, 3'b100, 1'b0, 3'd0, 1'b0});
    hold(2, 2, 2, "legal"); hold(0, 2, 5, "legal"); hold(1, 2, 3, "legal");
    hold(2, 2, 2, "legal"); hold(2, 0, 5, "legal"); hold(2, 1, 3, "legal");
    hold(2, 2, 1, "legal");
    chk("legal_nofault", {15'd0, bus.fault}, 16'd0);
    reset2();
    hold(0, 2, 1, "shorty"); hold(1, 2, 2, "shorty"); hold(2, 2, 1, "shorty");
    chk("shorty_code", {12'd0, bus.fault, bus.faultCode}, {12'd0, 1'b1, 3'd5});
    for (int i = 0; i < 12; i++) cyc(0, $urandom_range(3), $urandom_range(3), 0, "blink");
    reset2();
    cyc(0, 0, 3, 0, "illegal");
    chk("illegal_code", {13'd0, bus.faultCode}, 16'd1);
    chk("illegal_nogreen", {14'd0, bus.hwLamp[0], bus.farmLamp[0]}, 16'd0);
    reset2();
    hold(0, 2, 1, "g2r"); hold(2, 2, 1, "g2r");
    chk("g2r_code", {13'd0, bus.faultCode}, 16'd3);
    reset2();
    hold(2, 1, 1, "r2y");
    chk("r2y_code", {13'd0, bus.faultCode}, 16'd4);
    reset2();
    hold(0, 2, 1, "y2g"); hold(1, 2, 3, "y2g"); hold(0, 2, 1, "y2g");
    chk("y2g_code", {13'd0, bus.faultCode}, 16'd6);
    reset2();
    cyc(0, 2, 2, 1, "clr_normal");
    chk("clr_normal_nofault", {15'd0, bus.fault}, 16'd0);
    hold(0, 0, 1, "clr"); hold(2, 2, 4, "clr");
    chk("clr_off_phase", {10'd0, bus.hwLamp, bus.farmLamp}, 16'd0);
    cyc(0, 0, 0, 1, "clr_fault");
    chk("clr_result", {9'd0, bus.hwLamp, bus.farmLamp, bus.fault}, {9'd0, 3'b100, 3'b100, 1'b0});
    hold(1, 2, 1, "clr_hist");
    chk("clr_hist_code", {13'd0, bus.faultCode}, 16'd4);
    hold(2, 2, 3, "midrst");
    cyc(1, 0, 0, 0, "midrst");
    chk("midrst_out", {5'd0, bus.hwLamp, bus.farmLamp, bus.fault, bus.faultCode, bus.faultHold}, {5'd0, 3'b100, 3'b100, 1'b0, 3'd0, 1'b0});
    hw = 2; fm = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) hw = $urandom_range(3);
      if ($urandom_range(7) == 0) fm = $urandom_range(3);
      if ($urandom_range(9) == 0) begin hw = 2; fm = 2; end
      cyc($urandom_range(99) == 0 ? 1 : 0, hw, fm, $urandom_range(5) == 0 ? 1 : 0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
